// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a per-holder grant limit (MAX_HOLD cycles)
// and an active-low arbitration enable. All grant outputs come straight from flops.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Enable,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] last_q, last_d;
    logic [3:0] hold_q, hold_d;

    logic [1:0] winner;
    logic       any_req;
    logic       holder_req;
    logic       at_limit;
    logic       take_new;
    logic       go_idle;

    // Search starts just after the last winner; offset 4 wraps back onto the
    // last winner itself, which is how a lone holder gets re-granted at its limit.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
        logic [1:0] pick;
        logic       found;
        logic [1:0] cand;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign winner     = rr_pick(last_q, req);
    assign any_req    = |req;
    assign holder_req = req[idx_q];
    assign at_limit   = (hold_q >= 4'(MAX_HOLD));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        take_new = 1'b0;
        go_idle  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!Enable && any_req) take_new = 1'b1;
                else                    go_idle  = 1'b1;
            end
            GRANT: begin
                if (Enable)                go_idle  = 1'b1;
                else if (!holder_req)      take_new = any_req;
                else if (at_limit)         take_new = 1'b1;
                if (!Enable && !holder_req && !any_req) go_idle = 1'b1;
            end
            default: go_idle = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        hold_d  = hold_q;
        if (go_idle) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            hold_d  = 4'd0;
        end else if (take_new) begin
            state_d = GRANT;
            idx_d   = winner;
            last_d  = winner;
            hold_d  = 4'd1;
        end else if (state_q == GRANT) begin
            hold_d  = hold_q + 4'd1;
        end
        gnt_d = (state_d == GRANT) ? (4'b0001 << idx_d) : 4'b0000;
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            idx_q   <= 2'd0;
            last_q  <= 2'b11;
            hold_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed vector table, hand-written
// reset/rotation sequences, and random traffic against a rule-level model.
module tb_rr_arbiter4;

    localparam int MH = 4;

    logic       clk;
    logic       rst_n;
    logic       Enable;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int checks   = 0;
    int failures = 0;

    rr_arbiter4 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Enable    (Enable),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
    } vec_t;

    vec_t tbl[20];

    // Reference model: who owns the resource, for how long, and who won last.
    bit m_valid;
    int m_owner;
    int m_last;
    int m_held;
    int wait_cnt[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int next_in_turn(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_owner = 0;
        m_last  = 3;
        m_held  = 0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    endtask

    task automatic model_award(input logic [3:0] r);
        int w;
        w = next_in_turn(m_last, r);
        if (w < 0) begin
            m_valid = 1'b0;
            m_owner = 0;
            m_held  = 0;
        end else begin
            m_valid = 1'b1;
            m_owner = w;
            m_last  = w;
            m_held  = 1;
        end
    endtask

    task automatic model_edge(input logic en, input logic [3:0] r);
        if (en) begin
            m_valid = 1'b0;
            m_owner = 0;
            m_held  = 0;
        end else if (!m_valid || !r[m_owner] || m_held == MH) begin
            model_award(r);
        end else begin
            m_held++;
        end
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        Enable = 1'b0;
        req    = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic en, input logic [3:0] r);
        Enable = en;
        req    = r;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_gnt;
    logic [3:0] r_rand;
    logic       en_rand;
    int         worst;

    initial begin
        rst_n  = 1'b1;
        Enable = 1'b0;
        req    = 4'b0000;
        #1 rst_n = 1'b0;
        #2;
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_idx", 32'(gnt_idx), 32'h0);
        check("reset_valid", 32'(gnt_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0]  = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1};
        tbl[1]  = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
        tbl[2]  = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
        tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        for (int i = 4; i <= 12; i++) tbl[i] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[13] = '{1'b0, 4'b0101, 4'b0100, 2'd2, 1'b1};
        tbl[14] = '{1'b1, 4'b0101, 4'b0000, 2'd0, 1'b0};
        tbl[15] = '{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1};
        tbl[16] = '{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1};
        tbl[17] = '{1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0};
        tbl[18] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[19] = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1};

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].en, tbl[i].req);
            check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            check($sformatf("tbl%0d_valid", i), 32'(gnt_valid), 32'(tbl[i].valid));
            if (tbl[i].valid) check($sformatf("tbl%0d_idx", i), 32'(gnt_idx), 32'(tbl[i].idx));
        end

        // Quiet bus: nothing requested, nothing granted.
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 4'b0000);
            check("idle_gnt", 32'(gnt), 32'h0);
            check("idle_valid", 32'(gnt_valid), 32'h0);
        end

        // All four requesting: each owner keeps the grant exactly MH edges.
        for (int c = 0; c < 5 * MH; c++) begin
            step(1'b0, 4'b1111);
            check($sformatf("rot%0d_gnt", c), 32'(gnt), 32'(4'b0001 << ((c / MH) % 4)));
            check($sformatf("rot%0d_valid", c), 32'(gnt_valid), 32'h1);
        end

        // Asynchronous reset in the middle of a grant clears outputs without a clock.
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'h0);
        check("async_rst_valid", 32'(gnt_valid), 32'h0);
        req = 4'b1000;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 4'b1000);
        check("post_rst_gnt", 32'(gnt), 32'h8);
        check("post_rst_idx", 32'(gnt_idx), 32'h3);

        // Random traffic against the model, with a starvation watchdog.
        apply_reset();
        r_rand = 4'b0000;
        for (int c = 0; c < 800; c++) begin
            en_rand = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) r_rand = 4'($urandom_range(0, 15));
            step(en_rand, r_rand);
            model_edge(en_rand, r_rand);
            exp_gnt = m_valid ? (4'b0001 << m_owner) : 4'b0000;
            check("rand_gnt", 32'(gnt), 32'(exp_gnt));
            check("rand_valid", 32'(gnt_valid), 32'(m_valid));
            if (m_valid) check("rand_idx", 32'(gnt_idx), 32'(m_owner));
            check("rand_onehot", 32'($onehot0(gnt)), 32'h1);
            worst = 0;
            for (int i = 0; i < 4; i++) begin
                if (r_rand[i] && !en_rand && !gnt[i]) wait_cnt[i]++;
                else                                 wait_cnt[i] = 0;
                if (wait_cnt[i] > worst) worst = wait_cnt[i];
            end
            check("rand_fair", 32'(worst <= 3 * MH), 32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

endmodule
